mc_control: RTL
===============

Name: mc_control

Overview:
Multi-cycle successor to the single-cycle main decoder; a Moore FSM that sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives the datapath mux/enable controls. Adds a memory ready handshake, an optional addi path, illegal-opcode and memory-timeout traps, and a retired-instruction counter. Sits between the IR opcode field and the shared-memory multi-cycle datapath.

Parameters:
CNT_W, 32, width of retired-instruction counter
ENABLE_ADDI, 1, 1: opcode 001000 decoded as addi; 0: opcode 001000 traps as illegal
MEM_TIMEOUT, 0, max wait cycles with mem_ready_i low before trap; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
Op_i  in  6  opcode from IR; stable from DECODE until next FETCH
mem_ready_i  in  1  memory completes access this cycle
PCWrite_o  out  1  unconditional PC write
PCWriteCond_o  out  1  PC write if ALU zero
IorD_o  out  1  memory address: 0 PC, 1 ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  IR load
MemtoReg_o  out  1  write-back data: 0 ALUOut, 1 MDR
RegDst_o  out  1  dest reg: 0 rt, 1 rd
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0 PC, 1 reg A
ALUSrcB_o  out  2  0 reg B, 1 const 4, 2 sext imm, 3 sext imm<<2
ALUOp_o  out  2  0 R-type (funct), 1 add, 2 sub
PCSrc_o  out  2  0 ALU result, 1 ALUOut, 2 jump target
state_o  out  4  current state encoding
retire_o  out  1  one-cycle pulse: instruction completed
exc_o  out  1  one-cycle pulse: trap taken
exc_code_o  out  2  0 none, 1 illegal opcode, 2 memory timeout; valid while exc_o=1, else 0
instr_cnt_o  out  CNT_W  retired instruction count

Behaviour:
- States (state_o): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 12. Values 13-15 unreachable; if entered, next state is FETCH.
- Reset: rst_i high at a clock edge -> state FETCH, instr_cnt_o 0, wait counter 0. Overrides any in-flight access. Outputs are Moore-decoded from state, except IRWrite_o/PCWrite_o in FETCH (gated by mem_ready_i). After reset, outputs equal the FETCH values. Any control output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=1, PCSrc=0, IRWrite=PCWrite=mem_ready_i. Next: DECODE if ready, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=1. Next by Op_i:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 with ENABLE_ADDI=1 -> ADDIEX
  - anything else -> TRAP, code 1
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=1. Next: MEMRD if Op_i=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Next: MEMWB on ready, else stay.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Next: FETCH on ready, else stay.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=0. Next: ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=2, PCWriteCond=1, PCSrc=1. Next: FETCH.
- JUMP: PCWrite=1, PCSrc=2. Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=1. Next: ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0. Next: FETCH.
- TRAP: exc_o=1, exc_code_o=latched code; no writes. Next: FETCH.
- Retire: retire_o=1 in MEMWB, ALUWB, BRANCH, JUMP, ADDIWB, and in MEMWR when mem_ready_i=1. instr_cnt_o increments on the same edge and wraps modulo 2^CNT_W. Never retires in TRAP.
- Latency (zero-wait memory): R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
- Timeout (MEM_TIMEOUT>0): wait counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle in those states with mem_ready_i=0. If the counter = MEM_TIMEOUT and ready=0 -> TRAP, code 2, with the request dropped in TRAP. mem_ready_i=1 in the same cycle wins: normal progress, no trap.
- mem_ready_i is ignored outside FETCH/MEMRD/MEMWR.

Test Plan:
- Reset mid-MEMRD (state 3) -> next cycle state_o=0, MemRead=1, IorD=0, instr_cnt_o=0, no retire_o.
- mem_ready_i tied 1, R-type (000000) -> states 0,1,6,7; RegWrite=RegDst=1 in state 7; retire_o pulse; count 0->1.
- lw (100011), ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; MemtoReg=1 in state 4; IRWrite=1 only in the ready FETCH cycle.
- Op_i=111111, then 001000 with ENABLE_ADDI=0 -> each gives DECODE->TRAP, exc_o=1, exc_code_o=1, no RegWrite/MemWrite, count unchanged; with ENABLE_ADDI=1, 001000 -> states 10,11 and retire.
- MEM_TIMEOUT=3, sw with ready stuck 0 -> MEMWR for 4 cycles, then TRAP code 2, MemWrite=0 in TRAP; repeat with ready=1 on the 4th cycle -> FETCH and retire, no trap.
- CNT_W=4, 16 back-to-back j (000010) -> PCWrite=1, PCSrc=2 each; instr_cnt_o wraps 15->0.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle main control FSM: sequences each instruction through fetch/decode/execute
// and drives the datapath mux and enable controls, with memory handshake and traps.
module mc_control #(
    parameter int CNT_W       = 32,
    parameter bit ENABLE_ADDI = 1'b1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       Op_i,
    input  logic             mem_ready_i,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             MemtoReg_o,
    output logic             RegDst_o,
    output logic             RegWrite_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic [1:0]       PCSrc_o,
    output logic [3:0]       state_o,
    output logic             retire_o,
    output logic             exc_o,
    output logic [1:0]       exc_code_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] CODE_ILLEGAL = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int WAIT_W     = TIMEOUT_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state, next_state;
    logic [1:0]        trap_code, next_code;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait, timeout;

    assign mem_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout  = TIMEOUT_EN && mem_wait && !mem_ready_i && (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_FETCH;
            trap_code <= 2'd0;
        end else begin
            state     <= next_state;
            trap_code <= next_code;
        end
    end

    // Wait counter restarts whenever the FSM changes state, so it only accumulates stall cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt    <= '0;
            instr_cnt_o <= '0;
        end else begin
            if (next_state != state)
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready_i)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire_o)
                instr_cnt_o <= instr_cnt_o + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_code  = trap_code;
        case (state)
            S_FETCH: begin
                if (mem_ready_i) next_state = S_DECODE;
                else if (timeout) begin
                    next_state = S_TRAP;
                    next_code  = CODE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (Op_i == OP_RTYPE)                    next_state = S_EXEC;
                else if (Op_i == OP_LW || Op_i == OP_SW) next_state = S_MEMADR;
                else if (Op_i == OP_BEQ)                 next_state = S_BRANCH;
                else if (Op_i == OP_J)                   next_state = S_JUMP;
                else if (ENABLE_ADDI && Op_i == OP_ADDI) next_state = S_ADDIEX;
                else begin
                    next_state = S_TRAP;
                    next_code  = CODE_ILLEGAL;
                end
            end
            S_MEMADR: next_state = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready_i) next_state = S_MEMWB;
                else if (timeout) begin
                    next_state = S_TRAP;
                    next_code  = CODE_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (mem_ready_i) next_state = S_FETCH;
                else if (timeout) begin
                    next_state = S_TRAP;
                    next_code  = CODE_TIMEOUT;
                end
            end
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // Moore decode; only the fetch IR/PC writes and the store retire look at mem_ready_i.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'd0;
        ALUOp_o       = 2'd0;
        PCSrc_o       = 2'd0;
        retire_o      = 1'b0;
        exc_o         = 1'b0;
        exc_code_o    = 2'd0;
        state_o       = state;
        case (state)
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'd1;
                ALUOp_o   = 2'd1;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o = 2'd3;
                ALUOp_o   = 2'd1;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'd2;
                ALUOp_o   = 2'd1;
            end
            S_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                retire_o   = 1'b1;
            end
            S_MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                retire_o   = mem_ready_i;
            end
            S_EXEC: ALUSrcA_o = 1'b1;
            S_ALUWB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
                retire_o   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'd2;
                PCWriteCond_o = 1'b1;
                PCSrc_o       = 2'd1;
                retire_o      = 1'b1;
            end
            S_JUMP: begin
                PCWrite_o = 1'b1;
                PCSrc_o   = 2'd2;
                retire_o  = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite_o = 1'b1;
                retire_o   = 1'b1;
            end
            S_TRAP: begin
                exc_o      = 1'b1;
                exc_code_o = trap_code;
            end
            default: ;
        endcase
    end

endmodule
